// File: rtl/reorder_buffer_pkg.sv
// Shared types and sizes for the reorder buffer.
//   REG_ADDR_WIDTH : virtual register index width
//   PREG_WIDTH     : physical register index width (32 architectural + 32 rename)
//   ROB_WIDTH      : log2 of the entry count
package reorder_buffer_pkg;

  localparam int REG_ADDR_WIDTH = 5;
  localparam int PREG_WIDTH     = 6;
  localparam int ROB_WIDTH      = 5;
  localparam int ROB_SIZE       = 1 << ROB_WIDTH;

  typedef logic [REG_ADDR_WIDTH-1:0] vreg_t;
  typedef logic [PREG_WIDTH-1:0]     preg_t;
  typedef logic [ROB_WIDTH-1:0]      rob_idx_t;
  typedef logic [ROB_WIDTH:0]        rob_cnt_t;

  localparam rob_cnt_t ROB_FULL = rob_cnt_t'(ROB_SIZE);

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_ROLLBACK = 1'b1
  } rob_state_t;

endpackage

// File: rtl/reorder_buffer_if.sv
// Bundle of all reorder buffer handshakes (decode push, writeback completion,
// retirement to the free list, flush and rollback restore to the map table).
//   master : decode / writeback / free-list side
//   slave  : the reorder buffer itself
interface reorder_buffer_if;
  import reorder_buffer_pkg::*;

  logic     alloc_valid;
  vreg_t    alloc_vreg;
  preg_t    alloc_new_preg;
  preg_t    alloc_old_preg;
  logic     alloc_ready;
  rob_idx_t alloc_index;

  logic     complete_valid;
  rob_idx_t complete_index;

  logic     retire_valid;
  logic     retire_ready;
  vreg_t    retire_vreg;
  preg_t    free_preg;

  logic     flush_in;
  logic     restore_valid;
  vreg_t    restore_vreg;
  preg_t    restore_preg;
  preg_t    release_preg;
  logic     busy;
  rob_cnt_t count;

  modport master (
    output alloc_valid, alloc_vreg, alloc_new_preg, alloc_old_preg,
    output complete_valid, complete_index,
    output retire_ready, flush_in,
    input  alloc_ready, alloc_index,
    input  retire_valid, retire_vreg, free_preg,
    input  restore_valid, restore_vreg, restore_preg, release_preg,
    input  busy, count
  );

  modport slave (
    input  alloc_valid, alloc_vreg, alloc_new_preg, alloc_old_preg,
    input  complete_valid, complete_index,
    input  retire_ready, flush_in,
    output alloc_ready, alloc_index,
    output retire_valid, retire_vreg, free_preg,
    output restore_valid, restore_vreg, restore_preg, release_preg,
    output busy, count
  );

endinterface

// File: rtl/reorder_buffer.sv
// In-order retirement and rollback unit for the renaming register file.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   rob   : reorder_buffer_if.slave (alloc / complete / retire / flush / restore)
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_RUN      | normal push / complete / retire
// ST_ROLLBACK | walk entries youngest-first restoring the map table
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input logic             clk,
  input logic             rst_n,
  reorder_buffer_if.slave rob
);

  rob_state_t          r_state;
  rob_state_t          w_state_nxt;
  rob_idx_t            r_head;
  rob_idx_t            r_tail;
  rob_idx_t            w_tail_m1;
  rob_cnt_t            r_count;
  logic [ROB_SIZE-1:0] r_valid;
  logic [ROB_SIZE-1:0] r_done;

  // Payload needs no reset: valid bits gate every use of it.
  vreg_t r_vreg     [ROB_SIZE];
  preg_t r_new_preg [ROB_SIZE];
  preg_t r_old_preg [ROB_SIZE];

  logic w_run;
  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_retire_valid;
  logic w_retire;
  logic w_complete;
  logic w_restore;

  assign w_run     = (r_state == ST_RUN);
  assign w_full    = (r_count == ROB_FULL);
  assign w_empty   = (r_count == '0);
  assign w_tail_m1 = r_tail - rob_idx_t'(1);

  assign rob.alloc_ready = w_run && !w_full && !rob.flush_in;
  assign rob.alloc_index = r_tail;
  assign w_push          = rob.alloc_valid && rob.alloc_ready;

  // A flush cycle squashes retirement and completion as well as allocation.
  assign w_retire_valid = w_run && r_valid[r_head] && r_done[r_head];
  assign w_retire       = w_retire_valid && rob.retire_ready && !rob.flush_in;
  assign w_complete     = w_run && !rob.flush_in && rob.complete_valid
                          && r_valid[rob.complete_index];
  assign w_restore      = !w_run && !w_empty;

  assign rob.retire_valid  = w_retire_valid;
  assign rob.retire_vreg   = w_retire_valid ? r_vreg[r_head]     : '0;
  assign rob.free_preg     = w_retire_valid ? r_old_preg[r_head] : '0;
  assign rob.restore_valid = w_restore;
  assign rob.restore_vreg  = w_restore ? r_vreg[w_tail_m1]     : '0;
  assign rob.restore_preg  = w_restore ? r_old_preg[w_tail_m1] : '0;
  assign rob.release_preg  = w_restore ? r_new_preg[w_tail_m1] : '0;
  assign rob.busy          = !w_run;
  assign rob.count         = r_count;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:      if (rob.flush_in) w_state_nxt = ST_ROLLBACK;
      ST_ROLLBACK: if (w_empty)      w_state_nxt = ST_RUN;
      default:                       w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_RUN;
    else        r_state <= w_state_nxt;
  end

  // Push, retire and restore never target the same slot: push needs a
  // non-full buffer, retire a non-empty one, and restore only runs in rollback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
      r_done  <= '0;
    end else begin
      if (w_push) begin
        r_valid[r_tail] <= 1'b1;
        r_done[r_tail]  <= 1'b0;
        r_tail          <= r_tail + rob_idx_t'(1);
      end
      if (w_complete) r_done[rob.complete_index] <= 1'b1;
      if (w_retire) begin
        r_valid[r_head] <= 1'b0;
        r_done[r_head]  <= 1'b0;
        r_head          <= r_head + rob_idx_t'(1);
      end
      if (w_restore) begin
        r_valid[w_tail_m1] <= 1'b0;
        r_done[w_tail_m1]  <= 1'b0;
        r_tail             <= w_tail_m1;
      end
      if (w_push && !w_retire)
        r_count <= r_count + rob_cnt_t'(1);
      else if (!w_push && (w_retire || w_restore))
        r_count <= r_count - rob_cnt_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_vreg[r_tail]     <= rob.alloc_vreg;
      r_new_preg[r_tail] <= rob.alloc_new_preg;
      r_old_preg[r_tail] <= rob.alloc_old_preg;
    end
  end

endmodule
